alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
Multi-cycle control sequencer for the ALU in the RISC-V core. It fetches an instruction over a req/ack instruction-memory port and decodes it into the ALU control fields (opcode, Funct3, Funct7, Imm_reg, Shamt). It then steps through EXEC/MEM/WB states, driving the data-memory handshake and the register-file write strobe. It owns the PC, including branch and JAL target calculation.

Parameters:
WIDTH, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles a memory request may wait for ack before bus error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
instr  in  32  instruction word, valid when imem_ack=1
imem_ack  in  1  instruction memory ack, one-cycle pulse
dmem_ack  in  1  data memory ack, one-cycle pulse
alu_rd  in  WIDTH  ALU RD output; bit0 is the branch-taken flag in EXEC
pc  out  WIDTH  current PC, also the imem address
alu_pc  out  WIDTH  pc+4, the link value presented to the ALU pc input
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  store qualifier, valid with dmem_req
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]
imm  out  12  I-type: instr[31:20]; S-type: {instr[31:25],instr[11:7]}; else 0
shamt  out  5  instr[24:20]
rs1_addr, rs2_addr, rd_addr  out  5 each  instr[19:15], instr[24:20], instr[11:7]
rf_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse per completed instruction
illegal  out  1  one-cycle pulse on unsupported opcode
bus_err  out  1  one-cycle pulse on memory timeout
misalign  out  1  one-cycle pulse on a target with bits[1:0] != 0

Behaviour:
- Reset rst: synchronous, active-high. Dominates every state, including mid-handshake.
  - On reset: state=FETCH, pc=RESET_PC, IR=0.
  - All strobes and pulses are 0; the timeout counter is 0.
  - imem_req rises on the first cycle after rst deasserts.
- All outputs are registered. Decode fields come from the registered IR (instruction register).
- States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH.
- FETCH:
  - imem_req=1, held until imem_ack.
  - An ack is honoured only while req is high. On ack, IR<=instr and go to DECODE; req drops on the next edge.
- DECODE: one cycle.
  - Supported opcodes: 0110011, 0010011, 1100011, 0000011, 0100011, 1101111.
  - Any other opcode: illegal=1, retire=0, pc<=pc+4, go to FETCH.
- EXEC: one cycle; the ALU is combinational and alu_rd is sampled at the end of EXEC.
  - Branch: if alu_rd[0]=1, target = pc + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); otherwise pc+4. retire=1, go to FETCH.
  - Load/store: go to MEM.
  - R-type/I-type/JAL: go to WB.
- MEM:
  - dmem_req=1 until dmem_ack; dmem_we=1 for a store.
  - Load: go to WB on ack.
  - Store: on ack, pc<=pc+4, retire=1, go to FETCH.
- WB: one cycle.
  - rf_we=1, except rf_we=0 when rd_addr=0.
  - pc<=pc+4, or for JAL pc<=pc+sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - retire=1, go to FETCH.
- alu_pc = pc+4 at all times, so JAL links the return address.
- Misaligned target (bits[1:0] != 0): misalign=1, pc<=pc+4, no jump; a JAL still writes the link in WB.
- Timeout:
  - The counter increments each cycle that imem_req or dmem_req is high without ack.
  - When the count reaches TIMEOUT: drop req, bus_err=1, counter<=0.
  - FETCH timeout retries the same pc. MEM timeout gives pc<=pc+4 with no rf_we and no retire.
- An ack arriving on the same cycle as the timeout wins: normal completion, no bus_err.
- PC arithmetic wraps modulo 2^WIDTH.
- Stray acks in non-requesting states are ignored.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc=0, all strobes 0; imem_req=1 on the first cycle after release.
- ADD (instr 32'h002081B3), ack after 3 cycles -> DECODE/EXEC/WB follow. rf_we high exactly one cycle with rd_addr=3, retire=1, then pc=4 and FETCH.
- BEQ +8 at pc=0x10 -> alu_rd=1 in EXEC gives pc=0x18; alu_rd=0 gives pc=0x14. No rf_we in either case.
- SW, dmem_ack withheld for 16 cycles -> bus_err pulse, dmem_req drops, pc=pc+4, no retire. Repeat with ack on cycle 16 -> normal store, no bus_err.
- JAL x1,-4 at pc=0x0 -> pc=0xFFFF_FFFC (wrap), rf_we with alu_pc=0x4. Opcode 7'b1111111 -> illegal pulse, pc+4.
- rst asserted mid-MEM with dmem_req=1 -> next edge: dmem_req=0, state FETCH, pc=RESET_PC; a late dmem_ack is ignored.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the RISC-V ALU.
// It owns the PC and the instruction register, and it drives the imem/dmem handshakes and the register-file write strobe.
module alu_seq_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] alu_rd,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_pc,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [11:0]      imm,
  output logic [4:0]       shamt,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             rf_we,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic             misalign,
  output logic [2:0]       fsm_state
);

  localparam int               CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] FOUR    = WIDTH'(4);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      ir;
  logic [CW-1:0]    tcount;
  logic [WIDTH-1:0] pc_nxt, pc_plus4, btarget, jtarget;
  logic             rf_we_nxt, retire_nxt, illegal_nxt, bus_err_nxt, misalign_nxt;
  logic             is_branch, is_load, is_store, is_jal, legal;
  logic             req_wait, timed_out, fetch_done, mem_done, fetch_to;
  logic             unused_alu_bits;

  function automatic logic [11:0] imm_of(input logic [31:0] w);
    case (w[6:0])
      OP_I, OP_LOAD: imm_of = w[31:20];
      OP_STORE:      imm_of = {w[31:25], w[11:7]};
      default:       imm_of = '0;
    endcase
  endfunction

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign shamt     = ir[24:20];
  assign rs1_addr  = ir[19:15];
  assign rs2_addr  = ir[24:20];
  assign rd_addr   = ir[11:7];
  assign fsm_state = state;

  assign unused_alu_bits = ^alu_rd[WIDTH-1:1];

  assign is_branch = (ir[6:0] == OP_BRANCH);
  assign is_load   = (ir[6:0] == OP_LOAD);
  assign is_store  = (ir[6:0] == OP_STORE);
  assign is_jal    = (ir[6:0] == OP_JAL);
  assign legal     = (ir[6:0] == OP_R) || (ir[6:0] == OP_I) || is_branch ||
                     is_load || is_store || is_jal;

  assign pc_plus4 = pc + FOUR;
  assign btarget  = pc + {{(WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign jtarget  = pc + {{(WIDTH-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Handshake: a request is held high until the one-cycle ack. An ack counts only
  // in the requesting state while req is high. If the ack arrives on the same
  // cycle as the timeout, the ack wins.
  assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
  assign mem_done   = (state == S_MEM) && dmem_req && dmem_ack;
  assign req_wait   = ((state == S_FETCH) && imem_req && !imem_ack) ||
                      ((state == S_MEM) && dmem_req && !dmem_ack);
  assign timed_out  = req_wait && (tcount == TO_LAST);
  assign fetch_to   = timed_out && (state == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Pulses are registered on the edge where the decision is made. WB effects are
  // issued on entry to WB, so rf_we lines up with the pre-jump pc and alu_pc.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    retire_nxt   = 1'b0;
    illegal_nxt  = 1'b0;
    bus_err_nxt  = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_done)     state_nxt   = S_DECODE;
        else if (timed_out) bus_err_nxt = 1'b1;
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
          illegal_nxt = 1'b1;
          pc_nxt      = pc_plus4;
          state_nxt   = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          retire_nxt = 1'b1;
          state_nxt  = S_FETCH;
          pc_nxt     = pc_plus4;
          if (alu_rd[0]) begin
            if (btarget[1:0] != 2'b00) misalign_nxt = 1'b1;
            else                       pc_nxt       = btarget;
          end
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt    = S_WB;
          retire_nxt   = 1'b1;
          misalign_nxt = is_jal && (jtarget[1:0] != 2'b00);
        end
      end
      S_MEM: begin
        if (mem_done) begin
          retire_nxt = 1'b1;
          if (is_store) begin
            pc_nxt    = pc_plus4;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timed_out) begin
          bus_err_nxt = 1'b1;
          pc_nxt      = pc_plus4;
          state_nxt   = S_FETCH;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        pc_nxt    = (is_jal && (jtarget[1:0] == 2'b00)) ? jtarget : pc_plus4;
      end
      default: state_nxt = S_FETCH;
    endcase
    rf_we_nxt = (state_nxt == S_WB) && (ir[11:7] != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      alu_pc   <= RESET_PC + FOUR;
      ir       <= '0;
      imm      <= '0;
      tcount   <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      alu_pc   <= pc_nxt + FOUR;
      if (fetch_done) begin
        ir  <= instr;
        imm <= imm_of(instr);
      end
      tcount   <= (req_wait && !timed_out) ? tcount + 1'b1 : '0;
      imem_req <= (state_nxt == S_FETCH) && !fetch_to;
      dmem_req <= (state_nxt == S_MEM);
      dmem_we  <= (state_nxt == S_MEM) && is_store;
      rf_we    <= rf_we_nxt;
      retire   <= retire_nxt;
      illegal  <= illegal_nxt;
      bus_err  <= bus_err_nxt;
      misalign <= misalign_nxt;
    end
  end

endmodule
